// File: rtl/hazard_pkg.sv
// Shared types for the scoreboard hazard unit: forward-select encodings,
// the in-flight tracker entry and a small age-to-select helper.
package hazard_pkg;

  // Forward-select encodings driven on fwd_rs_sel / fwd_rt_sel.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_X  = 2'd1,
    FWD_M  = 2'd2,
    FWD_WB = 2'd3
  } fwd_sel_e;

  // Widest register specifier the tracker entry can hold; narrower
  // specifiers are zero-extended into it.
  localparam int unsigned RD_MAX_W = 8;

  // One in-flight instruction between decode and register-file write.
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } trk_entry_t;

  // Entry 0 is X, entry 1 is M, anything older is WB/retire.
  function automatic fwd_sel_e age_sel(input int unsigned age);
    if (age == 0)      return FWD_X;
    else if (age == 1) return FWD_M;
    else               return FWD_WB;
  endfunction

endpackage

// File: rtl/hazard_pipe_tracker.sv
// Shift register of in-flight destination writes, one entry per pipeline
// stage between decode and register-file write. Entry 0 is the youngest.
module hazard_pipe_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned TRK_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_valid,
  input  logic [REG_W-1:0]             push_rd,
  input  logic                         push_load,
  output trk_entry_t [TRK_DEPTH-1:0]   entries
);

  trk_entry_t [TRK_DEPTH-1:0] trk;

  // Advance every entry one stage per cycle; a non-issuing decode injects a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trk <= '0;
    end else begin
      trk[0] <= '{valid: push_valid, rd: RD_MAX_W'(push_rd), is_load: push_load};
      for (int unsigned k = 1; k < TRK_DEPTH; k++) begin
        trk[k] <= trk[k-1];
      end
    end
  end

  assign entries = trk;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-stage hazard unit: detects RAW hazards against in-flight writes,
// chooses stall or forwarding, sequences redirect flushes and counts stalls.
module scoreboard_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned TRK_DEPTH = 3,
  parameter int unsigned FWD_EN    = 0,
  parameter int unsigned FLUSH_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_rd,
  input  logic             id_rt_rd,
  input  logic             id_wr,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush,
  output logic             issue,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [15:0]      stall_count
);

  localparam int unsigned FCNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  trk_entry_t [TRK_DEPTH-1:0] entries;
  logic [FCNT_W-1:0]          flush_cnt;
  logic                       rs_hit, rt_hit;
  logic                       rs_lduse, rt_lduse;
  fwd_sel_e                   rs_src, rt_src;
  logic                       raw_stall;

  hazard_pipe_tracker #(
    .REG_W     (REG_W),
    .TRK_DEPTH (TRK_DEPTH)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (issue & id_wr),
    .push_rd    (id_rd),
    .push_load  (id_is_load),
    .entries    (entries)
  );

  // Youngest-first scan: the first hit per source decides its forward source.
  always_comb begin
    rs_hit   = 1'b0;
    rt_hit   = 1'b0;
    rs_lduse = 1'b0;
    rt_lduse = 1'b0;
    rs_src   = FWD_RF;
    rt_src   = FWD_RF;
    for (int unsigned k = 0; k < TRK_DEPTH; k++) begin
      if (!rs_hit && id_valid && id_rs_rd && entries[k].valid &&
          entries[k].rd == RD_MAX_W'(id_rs)) begin
        rs_hit   = 1'b1;
        rs_src   = age_sel(k);
        rs_lduse = (k == 0) && entries[k].is_load;
      end
      if (!rt_hit && id_valid && id_rt_rd && entries[k].valid &&
          entries[k].rd == RD_MAX_W'(id_rt)) begin
        rt_hit   = 1'b1;
        rt_src   = age_sel(k);
        rt_lduse = (k == 0) && entries[k].is_load;
      end
    end
  end

  // Stall/flush/issue resolution; flush always wins over stall.
  always_comb begin
    if (FWD_EN != 0) raw_stall = rs_lduse | rt_lduse;
    else             raw_stall = rs_hit | rt_hit;
    flush = ex_redirect | (flush_cnt != '0);
    stall = raw_stall & ~flush;
    issue = id_valid & ~stall & ~flush;
    if (FWD_EN != 0 && !stall && !flush) begin
      fwd_rs_sel = rs_src;
      fwd_rt_sel = rt_src;
    end else begin
      fwd_rs_sel = FWD_RF;
      fwd_rt_sel = FWD_RF;
    end
  end

  // Flush sequencer: a redirect (re)loads the remaining flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                 flush_cnt <= '0;
    else if (ex_redirect)       flush_cnt <= FCNT_W'(FLUSH_LEN - 1);
    else if (flush_cnt != '0)   flush_cnt <= flush_cnt - 1'b1;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n)                            stall_count <= '0;
    else if (stall && stall_count != '1)   stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: three instances (stall-only, forwarding,
// stall-only with a deep tracker) share one stimulus stream. A history-based
// model predicts every output each cycle; directed scenarios add literal checks.
module tb_scoreboard_hazard_unit;

  logic       clk, rst_n;
  logic       id_valid, id_rs_rd, id_rt_rd, id_wr, id_is_load, ex_redirect;
  logic [2:0] id_rs, id_rt, id_rd;

  logic [2:0] a_stall, a_flush, a_issue;
  logic [1:0] a_rs [3];
  logic [1:0] a_rt [3];
  logic [15:0] a_cnt [3];

  int checks = 0;
  int errors = 0;

  // Model configuration per instance.
  int depth [3] = '{3, 3, 64};
  bit fwd   [3] = '{1'b0, 1'b1, 1'b0};
  localparam int FLEN = 2;

  // Model state: history of what each instance issued, age 0 = last cycle.
  bit       hv  [3][64];
  bit [2:0] hrd [3][64];
  bit       hl  [3][64];
  int       fc  [3];
  int       cnt [3];
  bit       model_ok = 1'b0;

  scoreboard_hazard_unit #(.REG_W(3), .TRK_DEPTH(3), .FWD_EN(0), .FLUSH_LEN(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_wr(id_wr), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(a_stall[0]),
    .flush(a_flush[0]), .issue(a_issue[0]), .fwd_rs_sel(a_rs[0]), .fwd_rt_sel(a_rt[0]),
    .stall_count(a_cnt[0]));

  scoreboard_hazard_unit #(.REG_W(3), .TRK_DEPTH(3), .FWD_EN(1), .FLUSH_LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_wr(id_wr), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(a_stall[1]),
    .flush(a_flush[1]), .issue(a_issue[1]), .fwd_rs_sel(a_rs[1]), .fwd_rt_sel(a_rt[1]),
    .stall_count(a_cnt[1]));

  scoreboard_hazard_unit #(.REG_W(3), .TRK_DEPTH(64), .FWD_EN(0), .FLUSH_LEN(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_wr(id_wr), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(a_stall[2]),
    .flush(a_flush[2]), .issue(a_issue[2]), .fwd_rs_sel(a_rs[2]), .fwd_rt_sel(a_rt[2]),
    .stall_count(a_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Age of the most recent in-flight write to src, or -1 if none.
  function automatic int youngest(input int j, input bit [2:0] src);
    for (int a = 0; a < depth[j]; a++)
      if (hv[j][a] && hrd[j][a] == src) return a;
    return -1;
  endfunction

  task automatic model_cycle();
    for (int j = 0; j < 3; j++) begin
      int  ars, art, ers, ert;
      bit  fl, raw, st, is;
      fl  = ex_redirect || (fc[j] != 0);
      ars = (id_valid && id_rs_rd) ? youngest(j, id_rs) : -1;
      art = (id_valid && id_rt_rd) ? youngest(j, id_rt) : -1;
      if (fwd[j]) raw = (ars == 0 && hl[j][0]) || (art == 0 && hl[j][0]);
      else        raw = (ars >= 0) || (art >= 0);
      st  = raw && !fl;
      is  = id_valid && !st && !fl;
      ers = (!fwd[j] || st || fl || ars < 0) ? 0 : (ars == 0 ? 1 : (ars == 1 ? 2 : 3));
      ert = (!fwd[j] || st || fl || art < 0) ? 0 : (art == 0 ? 1 : (art == 1 ? 2 : 3));
      if (model_ok) begin
        chk($sformatf("dut%0d.stall", j), int'(a_stall[j]), int'(st));
        chk($sformatf("dut%0d.flush", j), int'(a_flush[j]), int'(fl));
        chk($sformatf("dut%0d.issue", j), int'(a_issue[j]), int'(is));
        chk($sformatf("dut%0d.fwd_rs", j), int'(a_rs[j]), ers);
        chk($sformatf("dut%0d.fwd_rt", j), int'(a_rt[j]), ert);
        chk($sformatf("dut%0d.count", j), int'(a_cnt[j]), cnt[j]);
      end
      if (!rst_n) begin
        for (int a = 0; a < 64; a++) hv[j][a] = 1'b0;
        fc[j]  = 0;
        cnt[j] = 0;
      end else begin
        for (int a = 63; a > 0; a--) begin
          hv[j][a] = hv[j][a-1]; hrd[j][a] = hrd[j][a-1]; hl[j][a] = hl[j][a-1];
        end
        hv[j][0] = is && id_wr; hrd[j][0] = id_rd; hl[j][0] = id_is_load;
        fc[j] = ex_redirect ? FLEN - 1 : (fc[j] > 0 ? fc[j] - 1 : 0);
        if (st && cnt[j] < 65535) cnt[j]++;
      end
    end
    if (!rst_n) model_ok = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_rd = 0; id_rt_rd = 0;
    id_wr = 0; id_rd = 0; id_is_load = 0; ex_redirect = 0;
  endtask

  task automatic instr(input bit [2:0] rs, input bit rsr, input bit [2:0] rt, input bit rtr,
                       input bit wr, input bit [2:0] rd, input bit ld);
    id_valid = 1; id_rs = rs; id_rs_rd = rsr; id_rt = rt; id_rt_rd = rtr;
    id_wr = wr; id_rd = rd; id_is_load = ld;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    fork
      forever begin
        @(negedge clk);
        model_cycle();
      end
      begin
        tick();
        do_reset();
        // State just after reset.
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("rst.stall%0d", j), int'(a_stall[j]), 0);
          chk($sformatf("rst.flush%0d", j), int'(a_flush[j]), 0);
          chk($sformatf("rst.cnt%0d", j), int'(a_cnt[j]), 0);
        end

        // Stall-only: ADD rd=3 then a reader of r3 stalls three cycles.
        do_reset();
        instr(0, 0, 0, 0, 1, 3, 0);
        @(negedge clk); chk("s0.add_issue", int'(a_issue[0]), 1);
        tick();
        instr(3, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); chk($sformatf("s0.stall%0d", k), int'(a_stall[0]), 1);
          tick();
        end
        @(negedge clk);
        chk("s0.issue4", int'(a_issue[0]), 1);
        chk("s0.cnt", int'(a_cnt[0]), 3);
        tick();

        // Forwarding: load rd=2 then reader of rt=2 -> one stall, then M forward.
        do_reset();
        instr(0, 0, 0, 0, 1, 2, 1);
        tick();
        instr(0, 0, 2, 1, 0, 0, 0);
        @(negedge clk); chk("lu.stall", int'(a_stall[1]), 1);
        tick();
        @(negedge clk);
        chk("lu.fwd_rt", int'(a_rt[1]), 2);
        chk("lu.issue", int'(a_issue[1]), 1);
        tick();

        // Forwarding: two writers of r5, youngest (X) wins.
        do_reset();
        instr(0, 0, 0, 0, 1, 5, 0);
        tick();
        instr(0, 0, 0, 0, 1, 5, 0);
        tick();
        instr(5, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("yw.fwd_rs", int'(a_rs[1]), 1);
        chk("yw.stall", int'(a_stall[1]), 0);
        tick();

        // Redirect flush, bubbles, and restart on a second redirect.
        do_reset();
        instr(0, 0, 0, 0, 1, 6, 0);
        ex_redirect = 1;
        @(negedge clk); chk("fl.c1", int'(a_flush[0]), 1); chk("fl.iss1", int'(a_issue[0]), 0);
        tick();
        ex_redirect = 0;
        @(negedge clk); chk("fl.c2", int'(a_flush[0]), 1); chk("fl.iss2", int'(a_issue[0]), 0);
        tick();
        instr(6, 1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("fl.c3", int'(a_flush[0]), 0); chk("fl.bubble", int'(a_stall[0]), 0);
        tick();
        instr(0, 0, 0, 0, 1, 7, 0);
        ex_redirect = 1;
        @(negedge clk); chk("rf.c1", int'(a_flush[0]), 1);
        tick();
        @(negedge clk); chk("rf.c2", int'(a_flush[0]), 1);
        tick();
        ex_redirect = 0;
        @(negedge clk); chk("rf.c3", int'(a_flush[0]), 1);
        tick();
        @(negedge clk); chk("rf.c4", int'(a_flush[0]), 0); chk("rf.iss4", int'(a_issue[0]), 1);
        tick();

        // Reset during a stall with the tracker full.
        do_reset();
        instr(0, 0, 0, 0, 1, 1, 0); tick();
        instr(0, 0, 0, 0, 1, 2, 0); tick();
        instr(0, 0, 0, 0, 1, 3, 0); tick();
        instr(1, 1, 0, 0, 0, 0, 0);
        rst_n = 0;
        @(negedge clk); chk("rs.pre_stall", int'(a_stall[0]), 1);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("rs.stall", int'(a_stall[0]), 0);
        chk("rs.cnt", int'(a_cnt[0]), 0);
        tick();

        // Saturation: self-dependent chain on the deep instance passes 16'hFFFE.
        do_reset();
        instr(3, 1, 0, 0, 1, 3, 0);
        repeat (66625) tick();
        @(negedge clk);
        chk("sat.cnt", int'(a_cnt[2]), 16'hFFFF);
        tick();
        idle();
        tick();
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 SHALL have parameter REG_W, default 3, meaning register-specifier width (2**REG_W architectural registers).
REQ-002 SHALL have parameter TRK_DEPTH, default 3, meaning tracked in-flight stages between decode and register-file write (minimum 2).
REQ-003 SHALL have parameter FWD_EN, default 0, meaning 0 = stall-only mode and 1 = forwarding mode.
REQ-004 SHALL have parameter FLUSH_LEN, default 2, meaning flush cycles per redirect (minimum 1).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning reset, synchronous and active-low.
REQ-007 SHALL have port id_valid, input, 1 bit, meaning a valid instruction is in decode.
REQ-008 SHALL have ports id_rs and id_rt, input, REG_W bits each, meaning source specifiers.
REQ-009 SHALL have ports id_rs_rd and id_rt_rd, input, 1 bit each, meaning the decode instruction reads that source.
REQ-010 SHALL have port id_wr, input, 1 bit, meaning the decode instruction writes a register.
REQ-011 SHALL have port id_rd, input, REG_W bits, meaning the destination specifier.
REQ-012 SHALL have port id_is_load, input, 1 bit, meaning the decode instruction is a memory load.
REQ-013 SHALL have port ex_redirect, input, 1 bit, meaning a taken branch or jump is resolved in execute.
REQ-014 SHALL have port stall, output, 1 bit, meaning hold fetch and decode.
REQ-015 SHALL have port flush, output, 1 bit, meaning squash the fetch and decode instructions.
REQ-016 SHALL have port issue, output, 1 bit, meaning the decode instruction advances this cycle.
REQ-017 SHALL have ports fwd_rs_sel and fwd_rt_sel, output, 2 bits each, meaning 0 = register file, 1 = X, 2 = M, 3 = WB.
REQ-018 SHALL have port stall_count, output, 16 bits, meaning saturating count of stall cycles.

Function
REQ-019 SHALL maintain a tracker of TRK_DEPTH entries, each holding {valid, rd, is_load}, where entry 0 is X, entry 1 is M, and entries 2 and above are WB/retire.
REQ-020 SHALL shift the tracker every cycle; entry 0 loads {id_wr, id_rd, id_is_load} when issue is 1, otherwise a bubble (valid = 0).
REQ-021 SHALL match a source only when its read flag is 1, id_valid is 1, and a valid tracker entry has an equal rd; register 0 is not special.
REQ-022 SHALL, when FWD_EN = 0, assert stall combinationally on any source match against any entry, and drive both forward selects to 0.
REQ-023 SHALL, when FWD_EN = 1, take the youngest matching entry per source: entry 0 that is a load gives stall; entry 0 that is not a load gives sel 1; entry 1 gives sel 2; entry 2 or above gives sel 3.
REQ-024 SHALL drive the forward selects to 0 whenever stall or flush is 1.
REQ-025 SHALL drive flush = ex_redirect | (flush_cnt != 0); on ex_redirect, flush_cnt loads FLUSH_LEN-1, otherwise it decrements to 0.
REQ-026 SHALL restart the counter on a redirect that arrives during a flush.
REQ-027 SHALL give flush priority over stall, so that stall = 0 while flush = 1.
REQ-028 SHALL drive issue = id_valid & ~stall & ~flush.
REQ-029 SHALL increment stall_count on each stall cycle and saturate at 16'hFFFF.

Reset
REQ-030 SHALL, on a clk edge with rst_n = 0, clear every tracker valid bit, flush_cnt and stall_count to 0, including mid-flush or mid-stall.
REQ-031 SHALL produce stall = 0, flush = 0 (when ex_redirect = 0), both forward selects = 0 and stall_count = 0 in the cycle after reset.

Structure
REQ-032 SHALL place the forward-select encodings and the tracker entry typedef in shared package hazard_pkg.
REQ-033 SHALL implement the tracker as sub-module hazard_pipe_tracker, parametrised by REG_W and TRK_DEPTH.

Verification
REQ-034 SHALL cover: FWD_EN=0, issue ADD rd=3, then next cycle a read of rs=3 -> stall for 3 cycles, issue in the 4th, stall_count = 3.
REQ-035 SHALL cover: FWD_EN=1, load rd=2, then next cycle a read of rt=2 -> 1 stall cycle, then fwd_rt_sel = 2.
REQ-036 SHALL cover: FWD_EN=1, ADD rd=5 then ADD rd=5, then next cycle a read of rs=5 -> fwd_rs_sel = 1 (youngest wins), no stall.
REQ-037 SHALL cover: ex_redirect pulse with FLUSH_LEN=2 -> flush high for 2 cycles, issue = 0, two bubbles enter the tracker; a second redirect in cycle 2 -> flush high for 2 more cycles.
REQ-038 SHALL cover: rst_n low during a stall with the tracker full -> next cycle stall = 0 and stall_count = 0.
REQ-039 SHALL cover: stall_count preloaded to 16'hFFFE plus 3 stall cycles -> holds at 16'hFFFF.
